// File: rtl/context_cache_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : context_cache_scheduler (with EV_types package)
//  Purpose  : Per-thread status tracking, FIFO run queue and ContextCache
//             command sequencing for the context cache.
//  Revision : 1.0 - initial release
// ============================================================================

package EV_types;
    // Width of thread_id_t must match TID_W of the scheduler instance.
    typedef logic [2:0] thread_id_t;

    typedef enum logic [2:0] {
        no_thread        = 3'd0,
        work_queue       = 3'd1,
        wait_for_trigger = 3'd2,
        executing        = 3'd3,
        template_ctx     = 3'd4
    } thread_status_t;

    typedef enum logic [1:0] {
        fork_none       = 2'd0,
        fork_me_copy    = 2'd1,
        fork_other_copy = 2'd2,
        fork_other_pass = 2'd3
    } fork_enum_t;

    typedef enum logic [1:0] {
        exec_none  = 2'd0,
        exec_copy  = 2'd1,
        exec_pass  = 2'd2,
        exec_clear = 2'd3
    } exec_info_t;

    typedef struct packed {
        logic       incoming;
        thread_id_t incoming_id;
        logic       sleep;
        logic       delete;
        exec_info_t execute_info;
        thread_id_t execute_id;
        fork_enum_t forking_info;
        thread_id_t forking_id;
        thread_id_t fork_src_id;
        logic       fork_sleep;
    } ContextCache_Control;
endpackage

module context_cache_scheduler
    import EV_types::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [TID_W-1:0]   in_id,
    input  logic               y_valid,
    input  logic [1:0]         y_op,
    input  logic [1:0]         y_fork,
    input  logic               y_fork_sleep,
    input  logic [TID_W-1:0]   y_src_id,
    output logic               y_ready,
    input  logic               trig_valid,
    input  logic [TID_W-1:0]   trig_id,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output ContextCache_Control cmd,
    output logic               run_valid,
    output logic [TID_W-1:0]   run_id,
    output logic               err_trig
);

    localparam logic [1:0] c_op_delete  = 2'd0;
    localparam logic [1:0] c_op_sleep   = 2'd1;
    localparam logic [1:0] c_op_fork    = 2'd2;
    localparam logic [1:0] c_op_requeue = 2'd3;

    thread_status_t      status_q [NUM_THREADS];
    thread_status_t      status_d [NUM_THREADS];
    logic [TID_W-1:0]    queue_q  [NUM_THREADS];
    logic [TID_W-1:0]    queue_d  [NUM_THREADS];
    logic [TID_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [TID_W:0]      count_q, count_d;
    logic                cmd_valid_q, cmd_valid_d;
    ContextCache_Control cmd_q, cmd_d;
    logic                run_valid_q, run_valid_d;
    logic [TID_W-1:0]    run_id_q, run_id_d;
    logic                err_trig_q, err_trig_d;

    logic                free_found;
    logic [TID_W-1:0]    free_id;
    logic                cmd_free, fork_ok, y_go, in_go, trig_go, disp_go;
    fork_enum_t          fork_kind;
    logic [TID_W-1:0]    fork_src;

    // Lowest-numbered unused ID (scan downwards so the lowest match wins).
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (status_q[i] == no_thread) begin
                free_found = 1'b1;
                free_id    = TID_W'(i);
            end
        end
    end

    // The command register is free when empty or being accepted this cycle.
    assign cmd_free  = !cmd_valid_q || cmd_ready;
    assign fork_kind = fork_enum_t'(y_fork);
    assign fork_src  = (fork_kind == fork_me_copy) ? run_id_q : y_src_id;
    assign fork_ok   = free_found && (fork_kind != fork_none) &&
                       ((fork_kind == fork_me_copy) || (status_q[y_src_id] == template_ctx));

    // Fixed priority: yield > incoming > trigger > dispatch.
    assign y_ready  = run_valid_q && cmd_free && ((y_op != c_op_fork) || fork_ok);
    assign y_go     = y_valid && y_ready;
    assign in_ready = free_found && cmd_free && !y_go;
    assign in_go    = in_valid && in_ready;
    assign trig_go  = trig_valid && cmd_free && !y_go && !in_go;
    assign disp_go  = !run_valid_q && (count_q != '0) && cmd_free && !y_go && !in_go && !trig_go;

    assign in_id     = free_id;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign run_valid = run_valid_q;
    assign run_id    = run_id_q;
    assign err_trig  = err_trig_q;

    // Next-state: apply the selected event to status, queue and command register.
    always_comb begin
        logic                load;
        ContextCache_Control new_cmd;
        logic                push_a, push_b, pop;
        logic [TID_W-1:0]    push_a_id, push_b_id;

        status_d    = status_q;
        queue_d     = queue_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        cmd_d       = cmd_q;
        run_valid_d = run_valid_q;
        run_id_d    = run_id_q;
        err_trig_d  = 1'b0;
        load        = 1'b0;
        new_cmd     = '0;
        push_a      = 1'b0;
        push_b      = 1'b0;
        pop         = 1'b0;
        push_a_id   = '0;
        push_b_id   = '0;

        if (y_go) begin
            load        = 1'b1;
            run_valid_d = 1'b0;
            new_cmd.execute_id = run_id_q;
            case (y_op)
                c_op_delete: begin
                    status_d[run_id_q]   = no_thread;
                    new_cmd.delete       = 1'b1;
                    new_cmd.execute_info = exec_clear;
                end
                c_op_sleep: begin
                    status_d[run_id_q] = wait_for_trigger;
                    new_cmd.sleep      = 1'b1;
                end
                c_op_fork: begin
                    // Parent context is saved and requeued behind the child.
                    new_cmd.execute_info = exec_pass;
                    new_cmd.forking_info = fork_kind;
                    new_cmd.forking_id   = free_id;
                    new_cmd.fork_src_id  = fork_src;
                    new_cmd.fork_sleep   = y_fork_sleep;
                    status_d[run_id_q]   = work_queue;
                    if (y_fork_sleep) begin
                        status_d[free_id] = wait_for_trigger;
                        push_a            = 1'b1;
                        push_a_id         = run_id_q;
                    end else begin
                        status_d[free_id] = work_queue;
                        push_a            = 1'b1;
                        push_a_id         = free_id;
                        push_b            = 1'b1;
                        push_b_id         = run_id_q;
                    end
                end
                default: begin
                    status_d[run_id_q]   = work_queue;
                    new_cmd.execute_info = exec_pass;
                    push_a               = 1'b1;
                    push_a_id            = run_id_q;
                end
            endcase
        end else if (in_go) begin
            load                = 1'b1;
            status_d[free_id]   = work_queue;
            new_cmd.incoming    = 1'b1;
            new_cmd.incoming_id = free_id;
            push_a              = 1'b1;
            push_a_id           = free_id;
        end else if (trig_go) begin
            // A valid wake-up needs no cache command; only the queue changes.
            if (status_q[trig_id] == wait_for_trigger) begin
                status_d[trig_id] = work_queue;
                push_a            = 1'b1;
                push_a_id         = trig_id;
            end else begin
                err_trig_d = 1'b1;
            end
        end else if (disp_go) begin
            load                       = 1'b1;
            pop                        = 1'b1;
            status_d[queue_q[head_q]]  = executing;
            run_valid_d                = 1'b1;
            run_id_d                   = queue_q[head_q];
            new_cmd.execute_info       = exec_copy;
            new_cmd.execute_id         = queue_q[head_q];
        end

        if (load) begin
            cmd_valid_d = 1'b1;
            cmd_d       = new_cmd;
        end

        // Second push only ever accompanies the first, so it lands at tail+1.
        if (push_a) queue_d[tail_q] = push_a_id;
        if (push_b) queue_d[tail_q + TID_W'(1)] = push_b_id;
        tail_d  = tail_q + TID_W'(push_a) + TID_W'(push_b);
        head_d  = head_q + TID_W'(pop);
        count_d = count_q + (TID_W+1)'(push_a) + (TID_W+1)'(push_b) - (TID_W+1)'(pop);
    end

    // State registers; reset discards any pending command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                status_q[i] <= no_thread;
                queue_q[i]  <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            run_valid_q <= 1'b0;
            run_id_q    <= '0;
            err_trig_q  <= 1'b0;
        end else begin
            status_q    <= status_d;
            queue_q     <= queue_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            run_valid_q <= run_valid_d;
            run_id_q    <= run_id_d;
            err_trig_q  <= err_trig_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_context_cache_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_context_cache_scheduler
//  Purpose  : Directed vector table plus hand sequences for the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_context_cache_scheduler;
    import EV_types::*;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, y_valid, y_ready, y_fork_sleep;
    logic trig_valid, cmd_valid, cmd_ready, run_valid, err_trig;
    logic [2:0] in_id, y_src_id, trig_id, run_id;
    logic [1:0] y_op, y_fork;
    ContextCache_Control cmd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    context_cache_scheduler #(.NUM_THREADS(8), .TID_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .y_valid(y_valid), .y_op(y_op), .y_fork(y_fork), .y_fork_sleep(y_fork_sleep),
        .y_src_id(y_src_id), .y_ready(y_ready),
        .trig_valid(trig_valid), .trig_id(trig_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .run_valid(run_valid), .run_id(run_id), .err_trig(err_trig)
    );

    typedef struct {
        logic iv; logic yv; logic [1:0] yop; logic tv; logic [2:0] tid; logic cr;
        logic e_in_rdy; logic [2:0] e_in_id; logic e_y_rdy; logic e_cv;
        ContextCache_Control e_cmd; logic e_rv; logic [2:0] e_rid; logic e_err;
    } vec_t;

    vec_t vecs[$];

    // Expected command constructors.
    function automatic ContextCache_Control c_none();
        ContextCache_Control c = '0;
        return c;
    endfunction
    function automatic ContextCache_Control c_inc(input logic [2:0] id);
        ContextCache_Control c = '0;
        c.incoming = 1'b1; c.incoming_id = id;
        return c;
    endfunction
    function automatic ContextCache_Control c_exec(input exec_info_t info, input logic [2:0] id);
        ContextCache_Control c = '0;
        c.execute_info = info; c.execute_id = id;
        return c;
    endfunction
    function automatic ContextCache_Control c_sleep(input logic [2:0] id);
        ContextCache_Control c = '0;
        c.sleep = 1'b1; c.execute_id = id;
        return c;
    endfunction
    function automatic ContextCache_Control c_del(input logic [2:0] id);
        ContextCache_Control c = '0;
        c.delete = 1'b1; c.execute_info = exec_clear; c.execute_id = id;
        return c;
    endfunction

    function automatic vec_t mk(input logic iv, yv, input logic [1:0] yop, input logic tv,
                                input logic [2:0] tid, input logic cr, e_in_rdy,
                                input logic [2:0] e_in_id, input logic e_y_rdy, e_cv,
                                input ContextCache_Control e_cmd, input logic e_rv,
                                input logic [2:0] e_rid, input logic e_err);
        vec_t v;
        v.iv = iv; v.yv = yv; v.yop = yop; v.tv = tv; v.tid = tid; v.cr = cr;
        v.e_in_rdy = e_in_rdy; v.e_in_id = e_in_id; v.e_y_rdy = e_y_rdy; v.e_cv = e_cv;
        v.e_cmd = e_cmd; v.e_rv = e_rv; v.e_rid = e_rid; v.e_err = e_err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; y_valid = 0; y_op = 0; y_fork = 0; y_fork_sleep = 0;
        y_src_id = 0; trig_valid = 0; trig_id = 0; cmd_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0; #1;
    endtask

    // Wait (bounded) for a dispatch and check which thread was started.
    task automatic wait_run(input logic [2:0] id, input string name);
        int n = 0;
        while (!run_valid && n < 20) begin tick(); n++; end
        chk(name, {28'd0, run_valid, run_id}, {28'd0, 1'b1, id});
    endtask

    task automatic yield_op(input logic [1:0] op, input string name);
        y_valid = 1; y_op = op; #1;
        chk(name, y_ready, 1);
        tick(); y_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset arriving while a command is pending drops it.
        do_reset();
        cmd_ready = 0; in_valid = 1; tick(); in_valid = 0;
        chk("pending_before_reset", cmd_valid, 1);
        #2 rst = 1; #1;
        chk("reset_drops_pending", cmd_valid, 0);
        tick(); rst = 0; #1;
        chk("reset_cmd_zero", cmd, 0);
        chk("reset_flags", {run_valid, run_id, err_trig, in_ready, y_ready, in_id},
            {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0});

        // iv yv op tv tid cr | in_rdy in_id y_rdy cv cmd rv rid err
        vecs.push_back(mk(1,0,0,0,0,1, 1,0,0,0,c_none(),          0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,1,0,1,c_inc(0),          0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,2,0,1,c_inc(1),          0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,c_inc(2),          0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,0,1,c_inc(2),          0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,c_exec(exec_copy,0),1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,c_exec(exec_copy,0),1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,1,1,c_exec(exec_copy,0),1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,1,0,c_none(),          1,0,0));
        vecs.push_back(mk(0,1,1,0,0,1, 0,0,1,0,c_none(),          1,0,0));
        vecs.push_back(mk(0,0,0,1,0,1, 1,3,0,1,c_sleep(0),        0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,0,0,c_none(),          0,0,0));
        vecs.push_back(mk(0,1,3,0,0,1, 0,0,1,1,c_exec(exec_copy,1),1,1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,0,1,c_exec(exec_pass,1),0,0,0));
        vecs.push_back(mk(0,1,3,0,0,1, 0,0,1,1,c_exec(exec_copy,2),1,2,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,0,1,c_exec(exec_pass,2),0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,1,1,c_exec(exec_copy,0),1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,3,1,0,c_none(),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,4,1,1,c_inc(3),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,5,1,1,c_inc(4),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,6,1,1,c_inc(5),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,7,1,1,c_inc(6),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 0,0,1,1,c_inc(7),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 0,0,1,0,c_none(),          1,0,0));
        vecs.push_back(mk(1,1,3,0,0,1, 0,0,1,0,c_none(),          1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 0,0,0,1,c_exec(exec_pass,0),0,0,0));
        vecs.push_back(mk(1,1,3,0,0,1, 0,0,1,1,c_exec(exec_copy,1),1,1,0));
        vecs.push_back(mk(1,0,0,0,0,1, 0,0,0,1,c_exec(exec_pass,1),0,0,0));
        vecs.push_back(mk(1,1,3,0,0,1, 0,0,1,1,c_exec(exec_copy,2),1,2,0));
        vecs.push_back(mk(1,0,0,0,0,1, 0,0,0,1,c_exec(exec_pass,2),0,0,0));
        vecs.push_back(mk(1,1,0,0,0,1, 0,0,1,1,c_exec(exec_copy,3),1,3,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,3,0,1,c_del(3),          0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,1,c_inc(3),          0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,1,1,c_exec(exec_copy,4),1,4,0));

        for (int i = 0; i < vecs.size(); i++) begin
            logic ok;
            in_valid = vecs[i].iv; y_valid = vecs[i].yv; y_op = vecs[i].yop;
            trig_valid = vecs[i].tv; trig_id = vecs[i].tid; cmd_ready = vecs[i].cr;
            #1;
            ok = (in_ready === vecs[i].e_in_rdy) &&
                 (!vecs[i].e_in_rdy || in_id === vecs[i].e_in_id) &&
                 (y_ready === vecs[i].e_y_rdy) && (cmd_valid === vecs[i].e_cv) &&
                 (!vecs[i].e_cv || cmd === vecs[i].e_cmd) &&
                 (run_valid === vecs[i].e_rv) &&
                 (!vecs[i].e_rv || run_id === vecs[i].e_rid) &&
                 (err_trig === vecs[i].e_err);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%b id=%0d yr=%b cv=%b cmd=%h rv=%b rid=%0d err=%b expected rdy=%b id=%0d yr=%b cv=%b cmd=%h rv=%b rid=%0d err=%b",
                         i, in_ready, in_id, y_ready, cmd_valid, cmd, run_valid, run_id, err_trig,
                         vecs[i].e_in_rdy, vecs[i].e_in_id, vecs[i].e_y_rdy, vecs[i].e_cv,
                         vecs[i].e_cmd, vecs[i].e_rv, vecs[i].e_rid, vecs[i].e_err);
            end
            @(posedge clk); #1;
        end

        // Fork: ids 0,1 in use, id0 running.
        do_reset();
        in_valid = 1; tick(); tick(); in_valid = 0;
        wait_run(0, "fork_setup_run0");
        y_valid = 1; y_op = 2; y_fork = 2; y_src_id = 1; y_fork_sleep = 0; #1;
        chk("fork_other_nontemplate_stall", y_ready, 0);
        y_fork = 1; #1;
        chk("fork_me_copy_ready", y_ready, 1);
        tick(); y_valid = 0;
        chk("fork_cmd", {cmd_valid, cmd.forking_id, cmd.forking_info, cmd.fork_sleep, cmd.fork_src_id},
            {1'b1, 3'd2, fork_me_copy, 1'b0, 3'd0});
        wait_run(1, "fork_queue_first");
        yield_op(0, "fork_delete1_ready");
        wait_run(2, "fork_child_before_parent");
        yield_op(0, "fork_delete2_ready");
        wait_run(0, "fork_parent_after_child");

        // Trigger on an unused thread: one error pulse, no command.
        trig_valid = 1; trig_id = 5; tick(); trig_valid = 0;
        chk("err_trig_pulse", err_trig, 1);
        chk("err_trig_no_cmd", cmd_valid, 0);
        tick();
        chk("err_trig_one_cycle", err_trig, 0);

        // Sleeping fork child gives a trigger target; parent requeued alone.
        y_valid = 1; y_op = 2; y_fork = 1; y_fork_sleep = 1; tick(); y_valid = 0; y_fork_sleep = 0;
        chk("fork_sleep_cmd", {cmd_valid, cmd.forking_id, cmd.fork_sleep}, {1'b1, 3'd1, 1'b1});
        wait_run(0, "fork_sleep_parent_runs");

        // Simultaneous yield, incoming and trigger with a stalled cache.
        y_valid = 1; y_op = 3; in_valid = 1; trig_valid = 1; trig_id = 1; #1;
        chk("simul_yield_wins", {y_ready, in_ready}, {1'b1, 1'b0});
        tick(); y_valid = 0; cmd_ready = 0; #1;
        for (int k = 0; k < 4; k++) begin
            chk("simul_cmd_stable", {cmd_valid, cmd, in_ready}, {1'b1, c_exec(exec_pass, 0), 1'b0});
            tick();
        end
        cmd_ready = 1; #1;
        chk("simul_incoming_second", {in_ready, in_id}, {1'b1, 3'd2});
        tick(); in_valid = 0;
        chk("simul_incoming_cmd", {cmd_valid, cmd}, {1'b1, c_inc(2)});
        tick(); trig_valid = 0;
        chk("simul_trigger_no_cmd", {cmd_valid, err_trig}, {1'b0, 1'b0});
        wait_run(0, "simul_requeued_first");
        yield_op(3, "simul_requeue0_ready");
        wait_run(2, "simul_incoming_next");
        yield_op(3, "simul_requeue2_ready");
        wait_run(1, "simul_triggered_third");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
